// File: rtl/reqrsp_rr_mux_pkg.sv
// Shared types and helpers for the round-robin reqrsp multiplexer.
//
// rr_q_t / rr_p_t     : request and response payloads of the reqrsp channels.
// rr_req_t / rr_rsp_t : full request (q, q_valid, p_ready) and response
//                       (p, p_valid, q_ready) bundles. These are the default
//                       bundle types of reqrsp_rr_mux; other bundles with the
//                       same field names can be supplied at instantiation.
// idx_width()         : bits needed to index n items, never less than one.
package reqrsp_rr_mux_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [31:0] wdata;
  } rr_q_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } rr_p_t;

  typedef struct packed {
    rr_q_t q;
    logic  q_valid;
    logic  p_ready;
  } rr_req_t;

  typedef struct packed {
    rr_p_t p;
    logic  p_valid;
    logic  q_ready;
  } rr_rsp_t;

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reqrsp_rr_mux_fifo.sv
// In-order ID FIFO for reqrsp_rr_mux.
// It records which upstream port owns each outstanding request.
// The read side is the registered head entry, so the FIFO never falls through
// from push to pop in the same cycle.
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset (empties the FIFO)
//   push      : write wr_data; ignored while full
//   pop       : drop the head entry; ignored while empty
//   wr_data   : ID to store
//   rd_data   : ID at the head (stale when empty)
//   count     : current occupancy, 0..Depth
module reqrsp_rr_mux_fifo
  import reqrsp_rr_mux_pkg::*;
#(
  parameter int  Width      = 1,
  parameter int  Depth      = 4,
  localparam int PtrWidth   = idx_width(Depth),
  localparam int CountWidth = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [Width-1:0]      wr_data,
  output logic [Width-1:0]      rd_data,
  output logic [CountWidth-1:0] count
);

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic                full;
  logic                empty;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == CountWidth'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is left unreset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap explicitly so that depths which are not powers of two work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PtrWidth'(Depth - 1)) ? '0 : wr_ptr + PtrWidth'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PtrWidth'(Depth - 1)) ? '0 : rd_ptr + PtrWidth'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CountWidth'(1);
        2'b01:   count <= count - CountWidth'(1);
        default: count <= count;
      endcase
    end
  end

  push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/reqrsp_rr_mux.sv
// Round-robin multiplexer that shares one downstream reqrsp port between
// NrPorts upstream requesters.
// Requests are arbitrated round-robin and pass through combinationally.
// The grantee of every accepted request is queued in an ID FIFO, and the
// responses are steered back to the requesters in the same order.
//
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset
//   slv_req_i    : upstream requests (q, q_valid, p_ready), one per port
//   slv_rsp_o    : upstream responses (p, p_valid, q_ready), one per port
//   mst_req_o    : downstream request
//   mst_rsp_i    : downstream response
module reqrsp_rr_mux
  import reqrsp_rr_mux_pkg::*;
#(
  parameter int  NrPorts   = 2,
  parameter int  RespDepth = 4,
  parameter type req_t     = rr_req_t,
  parameter type rsp_t     = rr_rsp_t,
  localparam int IdxWidth  = idx_width(NrPorts)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  req_t slv_req_i [NrPorts],
  output rsp_t slv_rsp_o [NrPorts],
  output req_t mst_req_o,
  input  rsp_t mst_rsp_i
);

  localparam int CountWidth = $clog2(RespDepth + 1);

  logic [IdxWidth-1:0]   rr_q;
  logic [IdxWidth-1:0]   sel_q;
  logic                  lock_q;
  logic [IdxWidth-1:0]   arb_sel;
  logic [IdxWidth-1:0]   sel;
  logic [IdxWidth-1:0]   head;
  logic [CountWidth-1:0] fifo_count;
  logic                  full;
  logic                  empty;
  logic                  q_valid;
  logic                  q_hs;
  logic                  p_ready;
  logic                  p_hs;

  assign full  = (fifo_count == CountWidth'(RespDepth));
  assign empty = (fifo_count == '0);

  // Pick the first requesting port at or above rr_q, wrapping around.
  always_comb begin : arbitrate
    int   cand;
    logic found;
    cand    = 0;
    found   = 1'b0;
    arb_sel = rr_q;
    for (int i = 0; i < NrPorts; i++) begin
      cand = (int'(rr_q) + i) % NrPorts;
      if (!found && slv_req_i[IdxWidth'(cand)].q_valid) begin
        found   = 1'b1;
        arb_sel = IdxWidth'(cand);
      end
    end
  end

  // A stalled request keeps its port selected until it is accepted.
  // Without this, a late arrival could change the payload on mst_req_o
  // while it is still valid and not yet ready.
  // A full FIFO blocks new requests even if a response pops in the same
  // cycle, so there is no combinational path from the p channel to the
  // q channel.
  assign sel     = lock_q ? sel_q : arb_sel;
  assign q_valid = slv_req_i[sel].q_valid && !full && !rst_i;
  assign q_hs    = q_valid && mst_rsp_i.q_ready;
  assign p_ready = slv_req_i[head].p_ready && !empty && !rst_i;
  assign p_hs    = p_ready && mst_rsp_i.p_valid;

  // Only the winner sees q_ready, and only when the downstream accepts.
  // Only the FIFO head sees p_valid.
  always_comb begin
    mst_req_o         = '0;
    mst_req_o.q       = slv_req_i[sel].q;
    mst_req_o.q_valid = q_valid;
    mst_req_o.p_ready = p_ready;
    for (int k = 0; k < NrPorts; k++) begin
      slv_rsp_o[k]         = '0;
      slv_rsp_o[k].p       = mst_rsp_i.p;
      slv_rsp_o[k].p_valid = mst_rsp_i.p_valid && !empty && !rst_i && (head == IdxWidth'(k));
      slv_rsp_o[k].q_ready = q_hs && (sel == IdxWidth'(k));
    end
  end

  // After a grant, the pointer moves just past the granted port.
  // When nothing is accepted, the pointer stays where it is.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      sel_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      lock_q <= q_valid && !mst_rsp_i.q_ready;
      sel_q  <= sel;
      if (q_hs) begin
        rr_q <= (sel == IdxWidth'(NrPorts - 1)) ? '0 : sel + IdxWidth'(1);
      end
    end
  end

  reqrsp_rr_mux_fifo #(
    .Width (IdxWidth),
    .Depth (RespDepth)
  ) u_id_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (q_hs),
    .pop     (p_hs),
    .wr_data (sel),
    .rd_data (head),
    .count   (fifo_count)
  );

  rsp_while_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    mst_rsp_i.p_valid |-> !empty);

  mst_q_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (mst_req_o.q_valid && !mst_rsp_i.q_ready) |=>
      (mst_req_o.q_valid && (mst_req_o.q == $past(mst_req_o.q))));

  for (genvar g = 0; g < NrPorts; g++) begin : gen_slv_assert
    slv_q_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (slv_req_i[g].q_valid && !slv_rsp_o[g].q_ready) |=>
        (slv_req_i[g].q == $past(slv_req_i[g].q)));
  end

endmodule
